baccarat_dealer: RTL

- Sequential dealing controller for the baccarat game. It is the producer side of the hand-scoring path.
- Captures card values one at a time from the card source on each player `step` pulse.
- Populates player and banker hand registers, applies the third-card rules and declares the winner.
- Scores use the same rule as the combinational scorer: face value 1-9 counts as itself, values 0 and 10-15 count 0, hand total mod 10.

---
 rtl/baccarat_dealer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/baccarat_dealer.sv
// Baccarat dealing FSM: one card captured per step pulse, third-card rules applied, winner flagged in DONE.
// Cards land on the capturing edge; EVAL/EVAL_B take one cycle each and drop any step seen there.
module baccarat_dealer (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] new_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  typedef enum logic [3:0] {
    DEAL_P1 = 4'd0,
    DEAL_D1 = 4'd1,
    DEAL_P2 = 4'd2,
    DEAL_D2 = 4'd3,
    EVAL    = 4'd4,
    DEAL_P3 = 4'd5,
    EVAL_B  = 4'd6,
    DEAL_D3 = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t state, state_nxt;
  logic   ld_p1, ld_d1, ld_p2, ld_d2, ld_p3, ld_d3;
  logic   banker_draw;
  logic [3:0] p3_pt;

  function automatic logic [3:0] pt(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] s;
    s = {1'b0, pt(a)} + {1'b0, pt(b)} + {1'b0, pt(c)};
    if (s >= 5'd20)      s = s - 5'd20;
    else if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  assign pscore = hand_score(pcard1, pcard2, pcard3);
  assign dscore = hand_score(dcard1, dcard2, dcard3);

  always_ff @(posedge slow_clock) begin
    if (reset) state <= DEAL_P1;
    else       state <= state_nxt;
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      pcard1 <= 4'd0;
      pcard2 <= 4'd0;
      pcard3 <= 4'd0;
      dcard1 <= 4'd0;
      dcard2 <= 4'd0;
      dcard3 <= 4'd0;
    end else begin
      if (ld_p1) pcard1 <= new_card;
      if (ld_d1) dcard1 <= new_card;
      if (ld_p2) pcard2 <= new_card;
      if (ld_d2) dcard2 <= new_card;
      if (ld_p3) pcard3 <= new_card;
      if (ld_d3) dcard3 <= new_card;
    end
  end

  // Banker third-card table, keyed on the banker's two-card total and the player's third card.
  always_comb begin
    p3_pt       = pt(pcard3);
    banker_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (p3_pt != 4'd8);
      4'd4:             banker_draw = (p3_pt >= 4'd2) && (p3_pt <= 4'd7);
      4'd5:             banker_draw = (p3_pt >= 4'd4) && (p3_pt <= 4'd7);
      4'd6:             banker_draw = (p3_pt >= 4'd6) && (p3_pt <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DEAL_P1: if (step) state_nxt = DEAL_D1;
      DEAL_D1: if (step) state_nxt = DEAL_P2;
      DEAL_P2: if (step) state_nxt = DEAL_D2;
      DEAL_D2: if (step) state_nxt = EVAL;
      EVAL: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_nxt = DONE;
        else if (pscore <= 4'd5)              state_nxt = DEAL_P3;
        else if (dscore <= 4'd5)              state_nxt = DEAL_D3;
        else                                  state_nxt = DONE;
      end
      DEAL_P3: if (step) state_nxt = EVAL_B;
      EVAL_B:  state_nxt = banker_draw ? DEAL_D3 : DONE;
      DEAL_D3: if (step) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = DEAL_P1;
    endcase
  end

  always_comb begin
    ld_p1 = (state == DEAL_P1) && step;
    ld_d1 = (state == DEAL_D1) && step;
    ld_p2 = (state == DEAL_P2) && step;
    ld_d2 = (state == DEAL_D2) && step;
    ld_p3 = (state == DEAL_P3) && step;
    ld_d3 = (state == DEAL_D3) && step;
    done  = (state == DONE);
  end

  assign player_win = done && (pscore >= dscore);
  assign dealer_win = done && (dscore >= pscore);

endmodule
